// File: rtl/ps2mouse_cursor_funcmod.sv
// PS/2 mouse packet decoder: absolute clamped cursor, saturating wheel, button state.
// Optional macro PS2MOUSE_ACCEL_EN doubles X/Y deltas of magnitude >= 8.
`default_nettype none

module ps2mouse_cursor_funcmod #(
  parameter int XMAX   = 639,
  parameter int YMAX   = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        iTrig,
  input  logic [31:0] iData,
  output logic        oTrig,
  output logic [10:0] oX,
  output logic [10:0] oY,
  output logic [2:0]  oBtn,
  output logic [7:0]  oWheel,
  output logic        oErr,
  output logic        oDrop
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ADD, S_CLAMP} state_t;

  state_t             state_q, state_d;
  logic [27:0]        cap_q, cap_d;
  logic signed [9:0]  dx_q, dx_d, dy_q, dy_d;
  logic signed [12:0] sx_q, sx_d, sy_q, sy_d;
  logic [10:0]        x_q, x_d, y_q, y_d;
  logic [2:0]         btn_q, btn_d;
  logic [7:0]         wheel_q, wheel_d;
  logic [8:0]         wsum;
  logic               trig_q, trig_d, err_q, err_d, drop_q, drop_d;

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    wheel_d = wheel_q;
    trig_d  = 1'b0;
    err_d   = 1'b0;
    drop_d  = 1'b0;
    wsum    = {wheel_q[7], wheel_q} + {{5{cap_q[27]}}, cap_q[27:24]};

    if (state_q != S_IDLE && iTrig) drop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (iTrig) begin
          cap_d   = iData[27:0];
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!cap_q[3]) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          dx_d = {cap_q[4], cap_q[4], cap_q[15:8]};
          dy_d = {cap_q[5], cap_q[5], cap_q[23:16]};
          if (cap_q[6]) begin
            dx_d  = '0;
            err_d = 1'b1;
          end
          if (cap_q[7]) begin
            dy_d  = '0;
            err_d = 1'b1;
          end
`ifdef PS2MOUSE_ACCEL_EN
          // Forced deltas are zero, so the magnitude test already skips them.
          if (dx_d >= 10'sd8 || dx_d <= -10'sd8) dx_d = dx_d <<< 1;
          if (dy_d >= 10'sd8 || dy_d <= -10'sd8) dy_d = dy_d <<< 1;
`endif
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        // PS/2 positive Y points up while screen row 0 is the top.
        sx_d    = $signed({2'b00, x_q}) + $signed({{3{dx_q[9]}}, dx_q});
        sy_d    = $signed({2'b00, y_q}) - $signed({{3{dy_q[9]}}, dy_q});
        state_d = S_CLAMP;
      end
      default: begin
        if (sx_q < 13'sd0)                   x_d = '0;
        else if (sx_q > $signed(13'(XMAX)))  x_d = 11'(XMAX);
        else                                 x_d = sx_q[10:0];
        if (sy_q < 13'sd0)                   y_d = '0;
        else if (sy_q > $signed(13'(YMAX)))  y_d = 11'(YMAX);
        else                                 y_d = sy_q[10:0];
        if (wsum[8] != wsum[7]) wheel_d = wsum[8] ? 8'h80 : 8'h7F;
        else                    wheel_d = wsum[7:0];
        btn_d   = cap_q[2:0];
        trig_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      x_q     <= 11'(X_INIT);
      y_q     <= 11'(Y_INIT);
      btn_q   <= '0;
      wheel_q <= '0;
      trig_q  <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
      wheel_q <= wheel_d;
      trig_q  <= trig_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign oTrig  = trig_q;
  assign oX     = x_q;
  assign oY     = y_q;
  assign oBtn   = btn_q;
  assign oWheel = wheel_q;
  assign oErr   = err_q;
  assign oDrop  = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2mouse_cursor_funcmod.sv
// Directed bench for ps2mouse_cursor_funcmod; honours PS2MOUSE_ACCEL_EN in expectations.
`timescale 1ns/1ps
`default_nettype none

module tb_ps2mouse_cursor_funcmod;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        iTrig = 1'b0;
  logic [31:0] iData = '0;
  logic        oTrig, oErr, oDrop;
  logic [10:0] oX, oY;
  logic [2:0]  oBtn;
  logic [7:0]  oWheel;

  int total = 0;
  int bad   = 0;

  ps2mouse_cursor_funcmod dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .iTrig (iTrig),
    .iData (iData),
    .oTrig (oTrig),
    .oX    (oX),
    .oY    (oY),
    .oBtn  (oBtn),
    .oWheel(oWheel),
    .oErr  (oErr),
    .oDrop (oDrop)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic do_reset();
    @(negedge CLOCK);
    RESET = 1'b0;
    iTrig = 1'b0;
    @(negedge CLOCK);
    RESET = 1'b1;
  endtask

  // Drive a one-cycle iTrig; returns at the negedge after the sampling edge N.
  task automatic send(input logic [31:0] d);
    @(negedge CLOCK);
    iTrig = 1'b1;
    iData = d;
    @(negedge CLOCK);
    iTrig = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({oX, oY, oBtn, oWheel, oTrig, oErr, oDrop} !== {11'd320, 11'd240, 3'd0, 8'd0, 3'b000}) begin
      bad++;
      $display("FAIL reset: got X=%0d Y=%0d B=%b W=%0d T/E/D=%b%b%b want 320 240 000 0 000",
               oX, oY, oBtn, oWheel, oTrig, oErr, oDrop);
    end
  endtask

  task automatic test_basic();
    do_reset();
    send(32'h0F_05_0A_09);
    wait_cyc(2);
    total++;
    if (oTrig !== 1'b0) begin bad++; $display("FAIL basic_early: oTrig=%b want 0", oTrig); end
    wait_cyc(1);
    total++;
`ifdef PS2MOUSE_ACCEL_EN
    if ({oTrig, oX, oY, oBtn, oWheel} !== {1'b1, 11'd340, 11'd235, 3'b001, 8'hFF}) begin
`else
    if ({oTrig, oX, oY, oBtn, oWheel} !== {1'b1, 11'd330, 11'd235, 3'b001, 8'hFF}) begin
`endif
      bad++;
      $display("FAIL basic: T=%b X=%0d Y=%0d B=%b W=%h want 1 330(340 accel) 235 001 ff",
               oTrig, oX, oY, oBtn, oWheel);
    end
    wait_cyc(1);
    total++;
    if ({oTrig, oErr} !== 2'b00 || oBtn !== 3'b001) begin
      bad++;
      $display("FAIL basic_hold: T=%b E=%b B=%b want 0 0 001", oTrig, oErr, oBtn);
    end
  endtask

  task automatic test_clamp_low();
    do_reset();
    send(32'h00_00_00_18);
    wait_cyc(3);
    total++;
`ifdef PS2MOUSE_ACCEL_EN
    if (oX !== 11'd0 || oY !== 11'd240) begin
`else
    if (oX !== 11'd64 || oY !== 11'd240) begin
`endif
      bad++; $display("FAIL clamp_x_first: X=%0d Y=%0d want 64(0 accel) 240", oX, oY);
    end
    wait_cyc(6);
    send(32'h00_00_00_18);
    wait_cyc(3);
    total++;
    if (oX !== 11'd0 || oY !== 11'd240) begin
      bad++; $display("FAIL clamp_x_zero: X=%0d Y=%0d want 0 240", oX, oY);
    end
  endtask

  task automatic test_clamp_high();
    do_reset();
    send(32'h00_00_FF_08);
    wait_cyc(3);
    total++;
`ifdef PS2MOUSE_ACCEL_EN
    if (oX !== 11'd639) begin
`else
    if (oX !== 11'd575) begin
`endif
      bad++; $display("FAIL xmax_first: X=%0d want 575(639 accel)", oX);
    end
    send(32'h00_00_FF_08);
    wait_cyc(3);
    total++;
    if (oX !== 11'd639) begin bad++; $display("FAIL xmax_clamp: X=%0d want 639", oX); end
    send(32'h00_FF_00_08);
    wait_cyc(3);
    total++;
    if (oY !== 11'd0) begin bad++; $display("FAIL ytop_clamp: Y=%0d want 0", oY); end
    send(32'h00_00_00_28);
    wait_cyc(3);
    total++;
`ifdef PS2MOUSE_ACCEL_EN
    if (oY !== 11'd479) begin
`else
    if (oY !== 11'd256) begin
`endif
      bad++; $display("FAIL ydown: Y=%0d want 256(479 accel)", oY);
    end
    send(32'h00_00_00_28);
    wait_cyc(3);
    total++;
    if (oY !== 11'd479 || oX !== 11'd639) begin
      bad++; $display("FAIL ymax_clamp: X=%0d Y=%0d want 639 479", oX, oY);
    end
  endtask

  task automatic test_err();
    int trigs;
    do_reset();
    send(32'h00_03_03_00);
    wait_cyc(1);
    total++;
    if (oErr !== 1'b1) begin bad++; $display("FAIL err_sync_pulse: oErr=%b want 1", oErr); end
    trigs = 0;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(1);
      if (oTrig === 1'b1) trigs++;
    end
    total++;
    if (trigs != 0 || {oX, oY, oBtn, oWheel} !== {11'd320, 11'd240, 3'd0, 8'd0}) begin
      bad++;
      $display("FAIL err_sync_nochange: trigs=%0d X=%0d Y=%0d B=%b W=%0d want 0 320 240 000 0",
               trigs, oX, oY, oBtn, oWheel);
    end
    send(32'h00_01_7F_48);
    wait_cyc(1);
    total++;
    if ({oErr, oTrig} !== 2'b10) begin
      bad++; $display("FAIL err_ovf_pulse: E=%b T=%b want 1 0", oErr, oTrig);
    end
    wait_cyc(2);
    total++;
    if ({oErr, oTrig, oX, oY} !== {1'b0, 1'b1, 11'd320, 11'd239}) begin
      bad++; $display("FAIL err_ovf_update: E=%b T=%b X=%0d Y=%0d want 0 1 320 239",
                      oErr, oTrig, oX, oY);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] tmask, dmask;
    do_reset();
    @(negedge CLOCK);
    iData = 32'h00_00_01_08;
    iTrig = 1'b1;
    tmask = '0;
    dmask = '0;
    for (int c = 0; c < 9; c++) begin
      @(negedge CLOCK);
      tmask[c] = oTrig;
      dmask[c] = oDrop;
      iTrig = (c + 1 == 2) || (c + 1 == 4);
    end
    iTrig = 1'b0;
    total++;
    if (dmask !== 9'b000000100) begin
      bad++; $display("FAIL drop_mask: got %b want 000000100", dmask);
    end
    total++;
    if (tmask !== 9'b010001000) begin
      bad++; $display("FAIL trig_mask: got %b want 010001000", tmask);
    end
    total++;
`ifdef PS2MOUSE_ACCEL_EN
    if (oX !== 11'd322) begin
`else
    if (oX !== 11'd322) begin
`endif
      bad++; $display("FAIL b2b_x: X=%0d want 322", oX);
    end
  endtask

  task automatic test_wheel_sat();
    do_reset();
    for (int i = 0; i < 19; i++) begin
      send(32'h07_00_00_08);
      wait_cyc(3);
    end
    total++;
    if (oWheel !== 8'h7F || oX !== 11'd320) begin
      bad++; $display("FAIL wheel_pos_sat: W=%h X=%0d want 7f 320", oWheel, oX);
    end
    send(32'h08_00_00_08);
    wait_cyc(3);
    total++;
    if (oWheel !== 8'd119) begin bad++; $display("FAIL wheel_dec: W=%0d want 119", oWheel); end
    for (int i = 0; i < 32; i++) begin
      send(32'h08_00_00_08);
      wait_cyc(3);
    end
    total++;
    if (oWheel !== 8'h80) begin bad++; $display("FAIL wheel_neg_sat: W=%h want 80", oWheel); end
  endtask

  task automatic test_reset_mid();
    int trigs;
    do_reset();
    send(32'h00_00_01_0F);
    RESET = 1'b0;
    #1;
    total++;
    if ({oX, oY, oBtn, oWheel, oTrig, oErr, oDrop} !== {11'd320, 11'd240, 3'd0, 8'd0, 3'b000}) begin
      bad++; $display("FAIL reset_mid_async: X=%0d Y=%0d B=%b W=%0d want 320 240 000 0",
                      oX, oY, oBtn, oWheel);
    end
    wait_cyc(1);
    RESET = 1'b1;
    trigs = 0;
    for (int i = 0; i < 5; i++) begin
      wait_cyc(1);
      if (oTrig === 1'b1) trigs++;
    end
    total++;
    if (trigs != 0 || oX !== 11'd320 || oBtn !== 3'd0) begin
      bad++; $display("FAIL reset_mid_lost: trigs=%0d X=%0d B=%b want 0 320 000", trigs, oX, oBtn);
    end
  endtask

`ifdef PS2MOUSE_ACCEL_EN
  task automatic test_accel();
    do_reset();
    send(32'h00_00_05_08);
    wait_cyc(3);
    total++;
    if (oX !== 11'd325) begin bad++; $display("FAIL accel_small: X=%0d want 325", oX); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_clamp_low();
    test_clamp_high();
    test_err();
    test_back_to_back();
    test_wheel_sat();
    test_reset_mid();
`ifdef PS2MOUSE_ACCEL_EN
    test_accel();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
